// File: rtl/hue_wheel_pwm_pkg.sv
// hue_pkg: segment encoding and shared constants for the hue wheel PWM driver
package hue_pkg;
    typedef enum logic [2:0] {SEG_RY, SEG_YG, SEG_GC, SEG_CB, SEG_BM, SEG_MR} seg_t;
    localparam int NUM_SEGS = 6;
    localparam int BRIGHT_BITS = 8;
    function automatic seg_t seg_step(seg_t s, logic rev);
        return rev ? (s == SEG_RY ? SEG_MR : seg_t'(s - 3'd1))
                   : (s == SEG_MR ? SEG_RY : seg_t'(s + 3'd1));
    endfunction
endpackage

// File: rtl/hue_wheel_pwm_if.sv
// hue_wheel_pwm_if: control inputs and LED/status outputs of the hue wheel driver
interface hue_wheel_pwm_if;
    import hue_pkg::*;
    logic                   run_i;
    logic                   dir_i;
    logic [BRIGHT_BITS-1:0] bright_i;
    logic                   rgb_r_o;
    logic                   rgb_g_o;
    logic                   rgb_b_o;
    seg_t                   seg_o;
    logic                   hue_wrap_o;
    modport master (output run_i, dir_i, bright_i, input rgb_r_o, rgb_g_o, rgb_b_o, seg_o, hue_wrap_o);
    modport slave  (input run_i, dir_i, bright_i, output rgb_r_o, rgb_g_o, rgb_b_o, seg_o, hue_wrap_o);
endinterface

// File: rtl/hue_wheel_pwm_pwm_channel.sv
// pwm_channel: per-period duty latch and registered, polarity-corrected LED output
module pwm_channel #(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] cnt_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic                latch_i,
    output logic                led_o
);
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;
    always_comb begin
        // the period's first compare already uses the freshly latched duty
        duty_d = latch_i ? duty_i : duty_q;
        led_d  = (cnt_i < duty_d) ^ ACTIVE_LOW;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q <= '0;
            led_q  <= ACTIVE_LOW;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end
    assign led_o = led_q;
endmodule

// File: rtl/hue_wheel_pwm.sv
// hue_wheel_pwm: six-segment hue sweep with brightness-scaled per-channel PWM
module hue_wheel_pwm import hue_pkg::*; #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int CYCLE_MS   = 1000,
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1
) (
    input logic             clk,
    input logic             rst_n,
    hue_wheel_pwm_if.slave  io
);
    localparam int MAX = 2**PWM_BITS - 1;
    localparam longint TICK_DIV = longint'(CLK_HZ) * CYCLE_MS / 1000 / (NUM_SEGS * (2**PWM_BITS));
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PW = PWM_BITS + 9;
    if (TICK_DIV < 1) begin : g_bad_div
        $error("hue_wheel_pwm: clock too slow for requested CYCLE_MS/PWM_BITS");
    end
    logic [TW-1:0]       tick_q, tick_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d, pwm_q, pwm_d;
    seg_t                seg_q, seg_d;
    logic                wrap_q, wrap_d;
    logic                step_tick, step, at_end;
    logic [2:0][PWM_BITS-1:0] raw;
    logic [2:0]          led;
    always_comb begin
        step_tick = tick_q == TW'(TICK_DIV - 1);
        tick_d    = step_tick ? '0 : tick_q + 1'b1;
        step      = step_tick && io.run_i;
        at_end    = io.dir_i ? ramp_q == '0 : ramp_q == '1;
        ramp_d    = !step ? ramp_q : at_end ? {PWM_BITS{io.dir_i}} :
                    io.dir_i ? ramp_q - 1'b1 : ramp_q + 1'b1;
        seg_d     = step && at_end ? seg_step(seg_q, io.dir_i) : seg_q;
        wrap_d    = step && at_end && seg_q == (io.dir_i ? SEG_RY : SEG_MR);
        pwm_d     = pwm_q == PWM_BITS'(MAX - 1) ? '0 : pwm_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= '0;
            ramp_q <= '0;
            pwm_q  <= '0;
            seg_q  <= SEG_RY;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
            ramp_q <= ramp_d;
            pwm_q  <= pwm_d;
            seg_q  <= seg_d;
            wrap_q <= wrap_d;
        end
    end
    // raw[0]=R, raw[1]=G, raw[2]=B
    always_comb begin
        raw = '0;
        case (seg_q)
            SEG_RY:  begin raw[0] = '1;      raw[1] = ramp_q;  end
            SEG_YG:  begin raw[0] = ~ramp_q; raw[1] = '1;      end
            SEG_GC:  begin raw[1] = '1;      raw[2] = ramp_q;  end
            SEG_CB:  begin raw[1] = ~ramp_q; raw[2] = '1;      end
            SEG_BM:  begin raw[0] = ramp_q;  raw[2] = '1;      end
            SEG_MR:  begin raw[0] = '1;      raw[2] = ~ramp_q; end
            default: raw = '0;
        endcase
    end
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [PW-1:0] prod;
        assign prod = PW'(raw[i]) * (PW'(io.bright_i) + 1'b1);
        pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch (
            .clk(clk), .rst_n(rst_n), .cnt_i(pwm_q), .duty_i(PWM_BITS'(prod >> 8)),
            .latch_i(pwm_q == '0), .led_o(led[i])
        );
    end
    assign io.rgb_r_o    = led[0];
    assign io.rgb_g_o    = led[1];
    assign io.rgb_b_o    = led[2];
    assign io.seg_o      = seg_q;
    assign io.hue_wrap_o = wrap_q;
endmodule

// File: tb/tb_hue_wheel_pwm.sv
// tb_hue_wheel_pwm: directed + randomized checks against a hue-position reference model
module tb_hue_wheel_pwm;
    localparam int MAXV = 15, TD = 2, HUE_STEPS = 96;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    hue_wheel_pwm_if bus();
    hue_wheel_pwm #(.CLK_HZ(192000), .CYCLE_MS(1), .PWM_BITS(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .io(bus.slave)
    );
    int checks = 0, errors = 0, cyc_n = 0;
    int m_pos, m_k, m_pwm;
    int m_lat [3];
    logic [2:0] m_rgb;
    logic m_wrap;

    // Each channel follows the same hue profile shifted by 120 degrees (two segments).
    function automatic int raw_duty(int pos, int ch);
        int s, r;
        s = (pos / 16 + 6 - 2 * ch) % 6;
        r = pos % 16;
        if (s == 0 || s == 5) return MAXV;
        if (s == 1) return MAXV - r;
        if (s == 4) return r;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int np, d;
        if (!rst_n) begin
            m_pos = 0; m_k = 0; m_pwm = 0; m_lat = '{0, 0, 0}; m_rgb = 3'b111; m_wrap = 0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                d = raw_duty(m_pos, ch) * (int'(bus.bright_i) + 1) / 256;
                if (m_pwm == 0) m_lat[ch] = d;
                m_rgb[2 - ch] = !(m_pwm < m_lat[ch]);
            end
            m_pwm = (m_pwm + 1) % MAXV;
            m_wrap = 0;
            if (m_k % TD == TD - 1 && bus.run_i) begin
                np = bus.dir_i ? m_pos - 1 : m_pos + 1;
                m_wrap = np < 0 || np >= HUE_STEPS;
                m_pos = (np + HUE_STEPS) % HUE_STEPS;
            end
            m_k++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cyc_n++;
        chk("rgb", {bus.rgb_r_o, bus.rgb_g_o, bus.rgb_b_o}, m_rgb);
        chk("seg", bus.seg_o, m_pos / 16);
        chk("wrap", bus.hue_wrap_o, m_wrap);
    endtask

    initial begin
        int last_wrap, lr, lg, lb;
        bus.run_i = 0; bus.dir_i = 0; bus.bright_i = 0;
        repeat (10) cyc();
        rst_n = 1;
        cyc();
        chk("post_rst_rgb", {bus.rgb_r_o, bus.rgb_g_o, bus.rgb_b_o}, 3'b111);
        chk("post_rst_seg", bus.seg_o, 0);
        // forward sweep at full brightness, wrap spacing is one revolution
        bus.bright_i = 255; bus.run_i = 1;
        last_wrap = -1;
        repeat (2 * 192 + 20) begin
            cyc();
            if (bus.hue_wrap_o) begin
                if (last_wrap >= 0) chk("wrap_period", cyc_n - last_wrap, 192);
                last_wrap = cyc_n;
            end
        end
        // frozen at seg0 ramp5: duty counts over one period
        rst_n = 0; cyc(); rst_n = 1;
        for (int i = 0; i < 100 && m_pos != 5; i++) cyc();
        if (m_pos != 5) chk("t3_timeout", m_pos, 5);
        bus.run_i = 0;
        repeat (30) cyc();
        lr = 0; lg = 0; lb = 0;
        repeat (15) begin
            cyc();
            lr += int'(!bus.rgb_r_o); lg += int'(!bus.rgb_g_o); lb += int'(!bus.rgb_b_o);
        end
        chk("t3_r_low", lr, 15); chk("t3_g_low", lg, 5); chk("t3_b_low", lb, 0);
        bus.bright_i = 127;
        repeat (30) cyc();
        lr = 0;
        repeat (15) begin cyc(); lr += int'(!bus.rgb_r_o); end
        chk("t3_r_low_b127", lr, 7);
        // reverse from reset: first step wraps to seg5 ramp15
        rst_n = 0; cyc(); rst_n = 1;
        bus.dir_i = 1; bus.run_i = 1; bus.bright_i = 200;
        cyc(); cyc();
        chk("rev_first_seg", bus.seg_o, 5);
        chk("rev_first_wrap", bus.hue_wrap_o, 1);
        repeat (200) cyc();
        // randomized run/dir/brightness
        repeat (1500) begin
            bus.run_i = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) bus.dir_i = ~bus.dir_i;
            if ($urandom % 32 == 0) bus.bright_i = 8'($urandom);
            cyc();
        end
        // reset mid-sweep during seg3
        bus.dir_i = 0; bus.run_i = 1;
        for (int i = 0; i < 300 && m_pos / 16 != 3; i++) cyc();
        if (m_pos / 16 != 3) chk("t5_timeout", m_pos / 16, 3);
        rst_n = 0; cyc();
        chk("mid_rst_seg", bus.seg_o, 0);
        chk("mid_rst_rgb", {bus.rgb_r_o, bus.rgb_g_o, bus.rgb_b_o}, 3'b111);
        chk("mid_rst_wrap", bus.hue_wrap_o, 0);
        rst_n = 1;
        // brightness drop mid-period only takes effect from the next period
        bus.bright_i = 255;
        repeat (40) cyc();
        for (int i = 0; i < 40 && m_pwm != 7; i++) cyc();
        bus.bright_i = 0;
        for (int i = 0; i < 40 && m_pwm != 1; i++) cyc();
        if (m_pwm != 1) chk("t6_timeout", m_pwm, 1);
        lr = 0;
        for (int i = 0; i < 15; i++) begin
            lr += int'(!bus.rgb_r_o) + int'(!bus.rgb_g_o) + int'(!bus.rgb_b_o);
            if (i < 14) cyc();
        end
        chk("t6_all_off", lr, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
